ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. It sends command and argument bytes to the keyboard, e.g. 0xED/LED mask, 0xF4 enable, 0xFF reset.
- Sits beside ps2_keyboard on the same PS2_CLK/PS2_DAT pair and drives both lines open-drain through output enables.
- Reports completion or error to the host logic. tx_busy is the signal used to gate the receiver while a frame is in flight.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_line_filter.sv | 39 +++
 rtl/ps2_host_tx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame constants and parity helper.
package ps2_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned FRAME_EDGES = 10;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } tx_state_t;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer, FILTER_LEN-sample glitch filter and falling-edge pulse for one PS/2 line.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // A new level is taken only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line};
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                fall  <= level & ~sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, bit clocking by the device, ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES     = 6000,
    parameter int unsigned START_CYCLES       = 1000,
    parameter int unsigned FIRST_EDGE_TIMEOUT = 750000,
    parameter int unsigned FRAME_TIMEOUT      = 100000,
    parameter int unsigned FILTER_LEN         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned MAX_CNT = (FIRST_EDGE_TIMEOUT > INHIBIT_CYCLES) ?
                                      FIRST_EDGE_TIMEOUT : INHIBIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned CNT_CAP = (2 ** CNT_W) - 1;
    localparam int unsigned BIT_W   = $clog2(FRAME_EDGES + 1);

    // Last timer value of a phase, clamped so the compare saturates instead of aliasing.
    function automatic logic [CNT_W-1:0] last_of(input int unsigned n);
        int unsigned v;
        v = (n == 0) ? 0 : n - 1;
        if (v > CNT_CAP) v = CNT_CAP;
        return CNT_W'(v);
    endfunction

    localparam logic [CNT_W-1:0] INH_LAST   = last_of(INHIBIT_CYCLES);
    localparam logic [CNT_W-1:0] START_LAST = last_of(START_CYCLES);
    localparam logic [CNT_W-1:0] FIRST_LAST = last_of(FIRST_EDGE_TIMEOUT);
    localparam logic [CNT_W-1:0] FRAME_LAST = last_of(FRAME_TIMEOUT);

    logic clk_f, clk_fall, data_f, unused_data_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .line  (ps2_clk_i),
        .level (clk_f),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .line  (ps2_data_i),
        .level (data_f),
        .fall  (unused_data_fall)
    );

    tx_state_t              state, state_d;
    logic [CNT_W-1:0]       timer, timer_d;
    logic [BIT_W-1:0]       bit_cnt, bit_cnt_d;
    logic [FRAME_EDGES-1:0] shreg, shreg_d;
    logic                   first_seen, first_d;
    logic                   clk_oe_d, data_oe_d, busy_d, done_d, error_d;
    logic                   abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            first_seen  <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            bit_cnt     <= bit_cnt_d;
            shreg       <= shreg_d;
            first_seen  <= first_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            tx_busy     <= busy_d;
            tx_done     <= done_d;
            tx_error    <= error_d;
        end
    end

    always_comb begin
        state_d   = state;
        timer_d   = (timer == '1) ? timer : timer + CNT_W'(1);
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        first_d   = first_seen;
        clk_oe_d  = ps2_clk_oe;
        data_oe_d = ps2_data_oe;
        busy_d    = tx_busy;
        done_d    = 1'b0;
        error_d   = 1'b0;
        abort     = 1'b0;

        case (state)
            IDLE: begin
                timer_d = '0;
                // A write coinciding with the completion pulse still belongs to the old frame.
                if (tx_write && !tx_done && !tx_error) begin
                    shreg_d  = {1'b1, odd_parity(tx_data), tx_data};
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer >= INH_LAST) begin
                    data_oe_d = 1'b1;
                    timer_d   = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (timer >= START_LAST) begin
                    clk_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                    first_d   = 1'b0;
                    timer_d   = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (clk_fall) begin
                    data_oe_d = ~shreg[bit_cnt];
                    bit_cnt_d = bit_cnt + BIT_W'(1);
                    first_d   = 1'b1;
                    if (!first_seen) timer_d = '0;
                    if (bit_cnt == BIT_W'(FRAME_EDGES - 1)) begin
                        timer_d = '0;
                        state_d = ACK;
                    end
                end else if (timer >= (first_seen ? FRAME_LAST : FIRST_LAST)) begin
                    abort = 1'b1;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (!data_f) begin
                        timer_d = '0;
                        state_d = WAIT_IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (timer >= FRAME_LAST) begin
                    abort = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (clk_f && data_f) begin
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    timer_d   = '0;
                    state_d   = IDLE;
                end else if (timer >= FRAME_LAST) begin
                    abort = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            error_d   = 1'b1;
            busy_d    = 1'b0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            timer_d   = '0;
            state_d   = IDLE;
        end
    end

endmodule
